polarity_rr_encoder: RTL
========================

POLARITY_RR_ENCODER -- requirements
Module: polarity_rr_encoder

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 8, giving the number of pixel/event channels (legal range 2..64).
REQ-002 The module SHALL have parameter CH_W, default $clog2(NUM_CH), giving the channel-index width.
REQ-003 The module SHALL have parameter CONFLICT_MODE, default 0: 0 = drop 2'b11 requests and count them; 1 = split 2'b11 into an ON event followed by an OFF event.
REQ-004 The module SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port reset_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port req_i, input, NUM_CH*POLARITY bits: level requests; channel k uses bits [2k+1:2k], where [1] = ON and [0] = OFF.
REQ-007 The module SHALL have port ack_o, output, NUM_CH bits: one-hot, single-cycle consume pulse.
REQ-008 The module SHALL have port evt_valid_o, output, 1 bit: event available.
REQ-009 The module SHALL have port evt_ready_i, input, 1 bit: downstream accepts.
REQ-010 The module SHALL have port evt_ch_o, output, CH_W bits: granted channel index.
REQ-011 The module SHALL have port evt_pol_o, output, 1 bit: polarity, 1 = ON, 0 = OFF.
REQ-012 The module SHALL have port conflict_cnt_o, output, 16 bits: count of dropped 2'b11 requests, saturating.

Function
REQ-013 Polarity decode SHALL be: 2'b10 -> ON (1); 2'b01 -> OFF (0); 2'b00 -> no request; 2'b11 -> conflict.
REQ-014 The FSM states SHALL be IDLE, SEND and SPLIT.
REQ-015 In IDLE, the block SHALL grant the first channel with a nonzero request, searching from rr_ptr upward with wrap from NUM_CH-1 to 0.
REQ-016 In IDLE with no nonzero request, the block SHALL remain in IDLE, keep evt_valid_o=0 and keep ack_o=0.
REQ-017 On a non-conflict grant in IDLE, the block SHALL register ch and pol, go to SEND, and assert evt_valid_o the next cycle (latency 1 cycle from sample).
REQ-018 On a conflict grant with CONFLICT_MODE=0, the block SHALL, combinationally in the same IDLE cycle, assert ack_o[ch], increment conflict_cnt_o (saturating at 16'hFFFF), set rr_ptr=ch+1 (mod NUM_CH), stay in IDLE, and emit no event.
REQ-019 On a conflict grant with CONFLICT_MODE=1, the block SHALL register ch with pol=1, go to SEND, and mark the split as pending.
REQ-020 In SEND/SPLIT, evt_valid_o=1 and evt_ch_o/evt_pol_o SHALL remain stable until evt_valid_o&&evt_ready_i, irrespective of req_i changes.
REQ-021 On a SEND handshake with split pending, the block SHALL go to SPLIT with pol=0, without asserting ack_o.
REQ-022 On a final handshake (SEND without split, or SPLIT), the block SHALL assert ack_o[ch] combinationally in the same cycle, set rr_ptr=ch+1 (mod NUM_CH), and go to IDLE.
REQ-023 A request deasserted after grant SHALL still have its latched event delivered and acked.
REQ-024 ack_o SHALL be zero in every cycle without a consume; at most one bit SHALL be set per cycle.
REQ-025 The requester SHALL drop req on the edge on which ack is seen; IDLE samples the following cycle, so no duplicate event occurs.

Reset
REQ-026 While reset_i is high at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, evt_valid_o=0, evt_ch_o=0, evt_pol_o=0, conflict_cnt_o=0, ack_o=0 and clear split-pending.
REQ-027 Reset during SEND/SPLIT SHALL abandon the latched event with no ack; the first grant after reset starts from channel 0.

Structure
REQ-028 POLARITY (=2), the state enum type, and the ON/OFF/conflict encoding constants SHALL live in arbiter_pkg.
REQ-029 Round-robin selection SHALL be one sub-module, rr_pick, with inputs req mask and ptr, and outputs found and index; it SHALL be combinational and instantiated once.

Verification
REQ-030 The bench SHALL cover: NUM_CH=8, ready=1, ch3=2'b10 -> valid next cycle, ch=3, pol=1, ack_o=8'h08 in the handshake cycle, rr_ptr=4.
REQ-031 The bench SHALL cover: ch1=2'b01 and ch6=2'b10 held, rr_ptr=0 -> events ch1/OFF, then ch6/ON, then ch1 again after wrap (ch1 re-requests).
REQ-032 The bench SHALL cover: CONFLICT_MODE=0, ch2=2'b11 -> ack_o=8'h04 in the IDLE cycle, no valid, conflict_cnt_o=1; after 65536 conflicts it stays 16'hFFFF.
REQ-033 The bench SHALL cover: CONFLICT_MODE=1, ch5=2'b11 -> ch5/ON, then ch5/OFF, with a single ack_o=8'h20 on the second handshake.
REQ-034 The bench SHALL cover: ready low for 10 cycles with ch7/ON pending -> valid, ch and pol stable all 10 cycles, no ack; ack on the cycle ready rises.
REQ-035 The bench SHALL cover: reset_i pulsed while valid=1 -> next cycle valid=0, ack_o=0, cnt=0, and the next grant searches from channel 0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared constants, state type and polarity encodings for the polarity
// round-robin event encoder.
package arbiter_pkg;

   localparam int POLARITY = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      SPLIT = 2'd2
   } state_t;

   // Two request bits per channel: [1] = ON, [0] = OFF
   localparam logic [1:0] POL_NONE     = 2'b00;
   localparam logic [1:0] POL_OFF      = 2'b01;
   localparam logic [1:0] POL_ON       = 2'b10;
   localparam logic [1:0] POL_CONFLICT = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit at or
// above the pointer, wrapping from NUM_CH-1 back to channel 0.
module rr_pick #(
   parameter int NUM_CH = 8,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] i_req,
   input  logic [CH_W-1:0]   i_ptr,
   output logic              o_found,
   output logic [CH_W-1:0]   o_index
);

   localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);

   logic [NUM_CH-1:0] w_rot;
   logic [CH_W:0]     w_sum;

   // Rotating the doubled mask puts the pointer channel at bit 0
   assign w_rot = NUM_CH'({i_req, i_req} >> i_ptr);

   always_comb begin
      o_found = 1'b0;
      w_sum   = {1'b0, i_ptr};
      for (int i = 0; i < NUM_CH; i++) begin
         if (!o_found && w_rot[i]) begin
            o_found = 1'b1;
            w_sum   = {1'b0, i_ptr} + (CH_W+1)'(i);
         end
      end
   end

   assign o_index = (w_sum >= NUM_CH_EXT) ? (w_sum[CH_W-1:0] - NUM_CH_EXT[CH_W-1:0])
                                          : w_sum[CH_W-1:0];

endmodule

// File: rtl/polarity_rr_encoder.sv
// Round-robin encoder turning per-channel ON/OFF level requests into a
// valid/ready event stream, with a one-hot ack when a request is consumed.
module polarity_rr_encoder
   import arbiter_pkg::*;
#(
   parameter int NUM_CH        = 8,
   parameter int CH_W          = $clog2(NUM_CH),
   parameter int CONFLICT_MODE = 0
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_CH*POLARITY-1:0]   req_i,
   output logic [NUM_CH-1:0]            ack_o,
   output logic                         evt_valid_o,
   input  logic                         evt_ready_i,
   output logic [CH_W-1:0]              evt_ch_o,
   output logic                         evt_pol_o,
   output logic [15:0]                  conflict_cnt_o
);

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH-1);

   state_t            r_state, w_next_state;
   logic [CH_W-1:0]   r_ptr, w_next_ptr;
   logic [CH_W-1:0]   r_ch, w_next_ch;
   logic              r_pol, w_next_pol;
   logic              r_split, w_next_split;
   logic [15:0]       r_cnt;

   logic [NUM_CH-1:0] w_active;
   logic              w_found;
   logic [CH_W-1:0]   w_pick_idx;
   logic [1:0]        w_code;
   logic              w_ack_en;
   logic [CH_W-1:0]   w_ack_ch;
   logic              w_conflict_drop;

   function automatic logic [CH_W-1:0] ptrAfter(input logic [CH_W-1:0] ch);
      return (ch == LAST_CH) ? '0 : ch + CH_W'(1);
   endfunction

   for (genvar k = 0; k < NUM_CH; k++) begin : g_active
      assign w_active[k] = (req_i[POLARITY*k +: POLARITY] != POL_NONE);
   end

   rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_pick (
      .i_req   (w_active),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_index (w_pick_idx)
   );

   assign w_code = req_i[{w_pick_idx, 1'b0} +: POLARITY];

   // Once latched, the event ignores req_i until its final handshake
   always_comb begin
      w_next_state    = r_state;
      w_next_ptr      = r_ptr;
      w_next_ch       = r_ch;
      w_next_pol      = r_pol;
      w_next_split    = r_split;
      w_ack_en        = 1'b0;
      w_ack_ch        = r_ch;
      w_conflict_drop = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               if (w_code == POL_CONFLICT && CONFLICT_MODE == 0) begin
                  w_ack_en        = 1'b1;
                  w_ack_ch        = w_pick_idx;
                  w_conflict_drop = 1'b1;
                  w_next_ptr      = ptrAfter(w_pick_idx);
               end else begin
                  w_next_ch    = w_pick_idx;
                  w_next_pol   = (w_code == POL_ON) || (w_code == POL_CONFLICT);
                  w_next_split = (w_code == POL_CONFLICT);
                  w_next_state = SEND;
               end
            end
         end
         SEND: begin
            if (evt_ready_i) begin
               if (r_split) begin
                  w_next_state = SPLIT;
                  w_next_pol   = 1'b0;
                  w_next_split = 1'b0;
               end else begin
                  w_ack_en     = 1'b1;
                  w_next_ptr   = ptrAfter(r_ch);
                  w_next_state = IDLE;
               end
            end
         end
         SPLIT: begin
            if (evt_ready_i) begin
               w_ack_en     = 1'b1;
               w_next_ptr   = ptrAfter(r_ch);
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_ch    <= '0;
         r_pol   <= 1'b0;
         r_split <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_ptr   <= w_next_ptr;
         r_ch    <= w_next_ch;
         r_pol   <= w_next_pol;
         r_split <= w_next_split;
         if (w_conflict_drop && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

   // Reset abandons an in-flight event, so it must not be acked either
   assign ack_o          = (w_ack_en && !reset_i) ? (NUM_CH'(1) << w_ack_ch) : '0;
   assign evt_valid_o    = (r_state != IDLE);
   assign evt_ch_o       = r_ch;
   assign evt_pol_o      = r_pol;
   assign conflict_cnt_o = r_cnt;

endmodule
